// File: rtl/alsu_req_sched_pkg.sv
// alsu_req_sched_pkg: shared opcodes, command layout and FSM encodings for the ALSU scheduler
package alsu_req_sched_pkg;

   localparam int CMD_W = 16;

   localparam logic [2:0] OP_AND   = 3'd0;
   localparam logic [2:0] OP_XOR   = 3'd1;
   localparam logic [2:0] OP_ADD   = 3'd2;
   localparam logic [2:0] OP_MUL   = 3'd3;
   localparam logic [2:0] OP_SHIFT = 3'd4;
   localparam logic [2:0] OP_ROT   = 3'd5;
   localparam logic [2:0] OP_INV6  = 3'd6;
   localparam logic [2:0] OP_INV7  = 3'd7;

   localparam int OPC_LSB   = 13;
   localparam int A_LSB     = 10;
   localparam int B_LSB     = 7;
   localparam int CIN_BIT   = 6;
   localparam int SIN_BIT   = 5;
   localparam int RED_A_BIT = 4;
   localparam int RED_B_BIT = 3;
   localparam int BYP_A_BIT = 2;
   localparam int BYP_B_BIT = 1;
   localparam int DIR_BIT   = 0;

   // Field order mirrors the packed command word, MSB first.
   typedef struct packed {
      logic [2:0] opcode;
      logic [2:0] a;
      logic [2:0] b;
      logic       cin;
      logic       serial_in;
      logic       red_op_a;
      logic       red_op_b;
      logic       bypass_a;
      logic       bypass_b;
      logic       direction;
   } alsu_cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Opcodes the ALSU treats as invalid.
   function automatic logic op_rejected(input logic [2:0] op);
      return (op == OP_INV6) || (op == OP_INV7);
   endfunction

endpackage

// File: rtl/alsu_req_sched_rr_arb2.sv
// rr_arb2: two-way round-robin grant; on a tie the requester not served last wins
module rr_arb2 (
   input  logic [1:0] req_valid,
   input  logic       rr_last,
   output logic [1:0] gnt
);

   // One-hot grant, zero when nobody requests.
   always_comb gnt = (&req_valid) ? (rr_last ? 2'b01 : 2'b10) : req_valid;

endmodule

// File: rtl/alsu_req_sched.sv
// alsu_req_sched: round-robin ALSU command scheduler with tagged valid/ready response.
// Optional macro ALSU_SCHED_OPCHK_EN: reject opcodes 6/7 locally instead of issuing them.
module alsu_req_sched
   import alsu_req_sched_pkg::*;
#(
   parameter int ALSU_LAT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [CMD_W-1:0] req_cmd0,
   input  logic [CMD_W-1:0] req_cmd1,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [5:0]       rsp_data,
   output logic             rsp_err,
   output logic [2:0]       alsu_A,
   output logic [2:0]       alsu_B,
   output logic [2:0]       alsu_opcode,
   output logic             alsu_cin,
   output logic             alsu_serial_in,
   output logic             alsu_red_op_A,
   output logic             alsu_red_op_B,
   output logic             alsu_bypass_A,
   output logic             alsu_bypass_B,
   output logic             alsu_direction,
   input  logic [5:0]       alsu_out,
   input  logic [15:0]      alsu_leds
);

   localparam int CNT_W = (ALSU_LAT < 2) ? 1 : $clog2(ALSU_LAT + 1);

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] wait_cnt;
   alsu_cmd_t        issued;
   alsu_cmd_t        cmd;
   logic             rr_last;
   logic [1:0]       gnt;
   logic             gid;
   logic             accept;
   logic             bad;

   rr_arb2 u_arb (
      .req_valid (req_valid),
      .rr_last   (rr_last),
      .gnt       (gnt)
   );

   assign gid    = gnt[1];
   assign cmd    = gid ? req_cmd1 : req_cmd0;
   assign accept = (state == ST_IDLE) && |gnt;

`ifdef ALSU_SCHED_OPCHK_EN
   assign bad = op_rejected(cmd.opcode);
`else
   assign bad = 1'b0;
`endif

   assign alsu_opcode    = issued.opcode;
   assign alsu_A         = issued.a;
   assign alsu_B         = issued.b;
   assign alsu_cin       = issued.cin;
   assign alsu_serial_in = issued.serial_in;
   assign alsu_red_op_A  = issued.red_op_a;
   assign alsu_red_op_B  = issued.red_op_b;
   assign alsu_bypass_A  = issued.bypass_a;
   assign alsu_bypass_B  = issued.bypass_b;
   assign alsu_direction = issued.direction;

   // State register.
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;

   // Next state: a rejected opcode skips the ALSU and answers on the next clock.
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: state_nx = accept ? (bad ? ST_RESP : ST_WAIT) : ST_IDLE;
         ST_WAIT: state_nx = (wait_cnt == '0) ? ST_RESP : ST_WAIT;
         ST_RESP: state_nx = rsp_ready ? ST_IDLE : ST_RESP;
         default: state_nx = ST_IDLE;
      endcase
   end

   // Accept strobe only for the granted requester while idle; held low during reset.
   always_comb req_ready = (state == ST_IDLE && !rst) ? gnt : 2'b00;

   // Issue, wait, capture and handshake datapath; alsu_* keep the last issued command.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         issued    <= '0;
         wait_cnt  <= '0;
         rr_last   <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE:
               if (accept) begin
                  rsp_id <= gid;
                  if (bad) begin
                     rsp_data  <= '0;
                     rsp_err   <= 1'b1;
                     rsp_valid <= 1'b1;
                  end else begin
                     issued   <= cmd;
                     wait_cnt <= CNT_W'(ALSU_LAT);
                  end
               end
            ST_WAIT:
               if (wait_cnt == '0) begin
                  rsp_data  <= alsu_out;
                  rsp_err   <= |alsu_leds;
                  rsp_valid <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - CNT_W'(1);
               end
            ST_RESP:
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rr_last   <= rsp_id;
               end
            default: ;
         endcase
      end

endmodule
